// File: rtl/real_stream_tx.sv
// Fixed-point real to little-endian byte stream transmitter.
// Optional header/sequence byte per word: define REAL_STREAM_TX_SEQ_EN.
module real_stream_tx #(
    parameter int IN_WIDTH  = 25,
    parameter int IN_EXP    = -9,
    parameter int OUT_WIDTH = 24,
    parameter int OUT_EXP   = -12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_value,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_data,
    output logic                out_last,
    output logic                sat_flag
);

    localparam int NBYTES = OUT_WIDTH / 8;
    localparam int S      = IN_EXP - OUT_EXP;
    localparam int SL     = (S > 0) ? S : 0;
    localparam int SR     = (S < 0) ? -S : 0;
    localparam int AW     = IN_WIDTH + SL + 1;
    localparam int CW     = ((AW > OUT_WIDTH) ? AW : OUT_WIDTH) + 1;
`ifdef REAL_STREAM_TX_SEQ_EN
    localparam int HB     = 1;
`else
    localparam int HB     = 0;
`endif
    localparam int FB     = NBYTES + HB;
    localparam int SW     = 8 * FB;
    localparam int IW     = $clog2(FB + 1);

    localparam logic signed [CW-1:0] MAXV =
        {{(CW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [CW-1:0] MINV =
        {{(CW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    if (OUT_WIDTH % 8 != 0) begin : g_bad_width
        $error("real_stream_tx: OUT_WIDTH must be a multiple of 8");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [SW-1:0]        r_shift;
    logic [IW-1:0]        r_idx;
    logic                 r_sat;

    logic signed [AW-1:0] w_ext;
    logic signed [AW-1:0] w_al;
    logic signed [CW-1:0] w_wide;
    logic                 w_hi;
    logic                 w_lo;
    logic                 w_sat;
    logic [OUT_WIDTH-1:0] w_word;
    logic [SW-1:0]        w_frame;
    logic                 w_load;
    logic                 w_take;

    // Widen first so the left shift cannot overflow; >>> floors toward -inf.
    assign w_ext  = {{(AW-IN_WIDTH){in_value[IN_WIDTH-1]}}, in_value};
    assign w_al   = (w_ext <<< SL) >>> SR;
    assign w_wide = {{(CW-AW){w_al[AW-1]}}, w_al};
    assign w_hi   = w_wide > MAXV;
    assign w_lo   = w_wide < MINV;
    assign w_sat  = w_hi | w_lo;

    always_comb begin
        w_word = w_wide[OUT_WIDTH-1:0];
        if (w_hi)
            w_word = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else if (w_lo)
            w_word = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end

`ifdef REAL_STREAM_TX_SEQ_EN
    logic [6:0] r_seq;
    assign w_frame = {w_word, w_sat, r_seq};

    always_ff @(posedge clk) begin
        if (rst)
            r_seq <= '0;
        else if (w_load)
            r_seq <= r_seq + 7'd1;
    end
`else
    assign w_frame = w_word;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_next = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = (r_idx == IW'(FB - 1));
                if (out_ready && out_last) begin
                    in_ready = 1'b1;
                    w_next   = in_valid ? SEND : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_load = in_valid & in_ready;
    assign w_take = out_valid & out_ready;

    // Byte 0 always sits in the low byte; each accepted byte shifts down.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_sat   <= 1'b0;
        end else if (w_load) begin
            r_shift <= w_frame;
            r_idx   <= '0;
            if (w_sat)
                r_sat <= 1'b1;
        end else if (w_take) begin
            r_shift <= r_shift >> 8;
            r_idx   <= r_idx + IW'(1);
        end
    end

    assign out_data = r_shift[7:0];
    assign sat_flag = r_sat;

endmodule

// File: tb/tb_real_stream_tx.sv
// Directed-vector bench for real_stream_tx (default parameters).
// Follows REAL_STREAM_TX_SEQ_EN the same way as the design.
module tb_real_stream_tx;

`ifdef REAL_STREAM_TX_SEQ_EN
    localparam int HB = 1;
`else
    localparam int HB = 0;
`endif
    localparam int FB = 3 + HB;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        sat_flag;

    int          n_vec = 0;
    int          n_err = 0;
    logic [6:0]  tb_seq = '0;
    logic [7:0]  r_exp [0:3];

    real_stream_tx dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build(input logic [23:0] w, input logic s);
        for (int k = 0; k < 4; k++)
            r_exp[k] = 8'h00;
`ifdef REAL_STREAM_TX_SEQ_EN
        r_exp[0] = {s, tb_seq};
        tb_seq   = tb_seq + 7'd1;
`endif
        for (int k = 0; k < 3; k++)
            r_exp[HB+k] = w[8*k +: 8];
    endtask

    task automatic expect_byte(input string tag, input int i);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(r_exp[i]));
        check({tag, "_last"}, 32'(out_last), 32'(i == FB - 1));
    endtask

    task automatic send(input string tag, input logic [24:0] v,
                        input logic [23:0] w, input logic s,
                        input logic sticky, input int stall_at,
                        input int stall_n);
        build(w, s);
        in_valid  = 1'b1;
        in_value  = v;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < FB; i++) begin
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int c = 0; c < stall_n; c++) begin
                    expect_byte({tag, "_stall"}, i);
                    tick();
                end
                out_ready = 1'b1;
            end
            expect_byte(tag, i);
            tick();
        end
        check({tag, "_idle"}, 32'(out_valid), 32'd0);
        check({tag, "_sat"}, 32'(sat_flag), 32'(sticky));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_value  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_sat", 32'(sat_flag), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        tick();

        send("one", 25'd512, 24'h001000, 1'b0, 1'b0, -1, 0);
        send("neg1", 25'h1FFFFFF, 24'hFFFFF8, 1'b0, 1'b0, -1, 0);
        send("satp", 25'h0400000, 24'h7FFFFF, 1'b1, 1'b1, -1, 0);
        send("satn", 25'h1000000, 24'h800000, 1'b1, 1'b1, -1, 0);
        send("bp", 25'd512, 24'h001000, 1'b0, 1'b1, HB + 1, 5);

        // Back-to-back: second word accepted on the first's last byte.
        in_valid  = 1'b1;
        in_value  = 25'd512;
        out_ready = 1'b1;
        build(24'h001000, 1'b0);
        tick();
        in_value = 25'h1FFFFFF;
        for (int i = 0; i < 2 * FB; i++) begin
            if (i == FB)
                build(24'hFFFFF8, 1'b0);
            expect_byte("b2b", i % FB);
            if (i == FB - 1)
                check("b2b_inready", 32'(in_ready), 32'd1);
            tick();
            if (i == FB - 1)
                in_valid = 1'b0;
        end
        check("b2b_idle", 32'(out_valid), 32'd0);

        // Reset mid-word, with a handshake attempt in the same cycle.
        build(24'h7FFFFF, 1'b1);
        in_valid = 1'b1;
        in_value = 25'h0400000;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_b1", 32'(out_data), 32'(r_exp[1]));
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_ready", 32'(in_ready), 32'd1);
        check("mid_sat", 32'(sat_flag), 32'd0);
        check("mid_data", 32'(out_data), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tb_seq   = '0;
        tick();
        check("mid_quiet", 32'(out_valid), 32'd0);

        send("post", 25'd512, 24'h001000, 1'b0, 1'b0, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
